// File: rtl/spi_master_if.sv
// SPI master bundle: host-side request/response and the serial pins.
// The master modport is the controller; the slave modport is its user.
interface spi_master_if;
  logic       start;
  logic [1:0] cmd;
  logic [7:0] payload;
  logic       busy;
  logic       done;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  modport master (
    input  start, cmd, payload, MISO,
    output busy, done, rd_data, rd_valid, SS_n, MOSI
  );

  modport slave (
    output start, cmd, payload, MISO,
    input  busy, done, rd_data, rd_valid, SS_n, MOSI
  );
endinterface

// File: rtl/spi_master.sv
// Frame-based SPI master: {cmd,payload} out MSB first, optional
// turnaround and 8-bit read-back, then an enforced SS_n-high gap.
module spi_master #(
  parameter int TURN_CYC = 2,
  parameter int GAP_CYC  = 1
) (
  input logic         clk,
  input logic         rst,
  spi_master_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, START, SHIFT, TURN, RECV, GAP
  } state_t;

  localparam logic [3:0] TURN_LD =
    (TURN_CYC > 0) ? 4'(TURN_CYC - 1) : 4'd0;
  localparam logic [3:0] GAP_LD = 4'(GAP_CYC - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [9:0] frame, frame_n;
  logic [7:0] rx, rx_n;
  logic [7:0] rd_q, rd_n;
  logic       ss_q, ss_d;
  logic       mosi_q, mosi_d;
  logic       done_q, done_d;
  logic       rv_q, rv_d;

  // State, datapath and registered pin drivers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      frame  <= '0;
      rx     <= '0;
      rd_q   <= '0;
      ss_q   <= 1'b1;
      mosi_q <= 1'b0;
      done_q <= 1'b0;
      rv_q   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      frame  <= frame_n;
      rx     <= rx_n;
      rd_q   <= rd_n;
      ss_q   <= ss_d;
      mosi_q <= mosi_d;
      done_q <= done_d;
      rv_q   <= rv_d;
    end
  end

  // Next state; pin values are computed for the state being entered.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    frame_n = frame;
    rx_n    = rx;
    rd_n    = rd_q;
    ss_d    = 1'b1;
    mosi_d  = 1'b0;
    done_d  = 1'b0;
    rv_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          frame_n = {bus.cmd, bus.payload};
          state_n = START;
          ss_d    = 1'b0;
          mosi_d  = bus.cmd[1];
        end
      end
      START: begin
        state_n = SHIFT;
        cnt_n   = 4'd9;
        ss_d    = 1'b0;
        mosi_d  = frame[9];
      end
      SHIFT: begin
        if (cnt != 4'd0) begin
          cnt_n  = cnt - 4'd1;
          ss_d   = 1'b0;
          mosi_d = frame[cnt - 4'd1];
        end else if (frame[9:8] == 2'b11) begin
          ss_d = 1'b0;
          if (TURN_CYC == 0) begin
            state_n = RECV;
            cnt_n   = 4'd7;
          end else begin
            state_n = TURN;
            cnt_n   = TURN_LD;
          end
        end else begin
          state_n = GAP;
          cnt_n   = GAP_LD;
          done_d  = 1'b1;
        end
      end
      TURN: begin
        ss_d = 1'b0;
        if (cnt == 4'd0) begin
          state_n = RECV;
          cnt_n   = 4'd7;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      RECV: begin
        rx_n = {rx[6:0], bus.MISO};
        if (cnt == 4'd0) begin
          state_n = GAP;
          cnt_n   = GAP_LD;
          done_d  = 1'b1;
          rv_d    = 1'b1;
          rd_n    = rx_n;
        end else begin
          cnt_n = cnt - 4'd1;
          ss_d  = 1'b0;
        end
      end
      GAP: begin
        if (cnt == 4'd0) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.busy     = (state != IDLE);
  assign bus.SS_n     = ss_q;
  assign bus.MOSI     = mosi_q;
  assign bus.done     = done_q;
  assign bus.rd_valid = rv_q;
  assign bus.rd_data  = rd_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave + RAM.
// Slave samples MOSI and drives MISO on the falling edge.
module tb_spi_master;

  localparam int TURN = 2;
  localparam int GAP  = 1;

  logic clk = 1'b0;
  logic rst;

  spi_master_if bus ();

  spi_master #(
    .TURN_CYC(TURN),
    .GAP_CYC (GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // slave + RAM model
  logic [7:0]  ram [256];
  logic [7:0]  s_addr;
  logic [10:0] s_sh;
  logic [7:0]  s_data;
  int          s_c;

  always @(negedge clk) begin : slave
    int          c;
    logic [10:0] sh;
    if (rst) begin
      s_addr   <= 8'h00;
      s_sh     <= '0;
      s_data   <= 8'h00;
      s_c      <= 0;
      ram[0]   <= 8'h3C;
      bus.MISO <= 1'b0;
    end else if (bus.SS_n !== 1'b0) begin
      s_c      <= 0;
      bus.MISO <= 1'b0;
    end else begin
      c = s_c + 1;
      s_c <= c;
      if (c <= 11) begin
        sh = {s_sh[9:0], bus.MOSI};
        s_sh <= sh;
        if (c == 11) begin
          case (sh[9:8])
            2'b00: s_addr <= sh[7:0];
            2'b01: ram[s_addr] <= sh[7:0];
            2'b10: s_addr <= sh[7:0];
            default: s_data <= ram[s_addr];
          endcase
        end
      end
      if (c >= 12 + TURN && c <= 19 + TURN)
        bus.MISO <= s_data[19 + TURN - c];
      else
        bus.MISO <= 1'b0;
    end
  end

  // per-frame observations
  int          low, done_at, rv_at, dn, rvn, idle_at, tail;
  logic [10:0] mosi_vec;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // one start pulse, optional stray start at cycle extra_at
  task automatic frame(input logic [1:0] c,
                       input logic [7:0] p,
                       input int extra_at);
    low = 0; done_at = 0; rv_at = 0; dn = 0;
    rvn = 0; idle_at = 0; tail = 0; mosi_vec = '0;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.cmd     = c;
    bus.payload = p;
    for (int k = 1; k <= 60 && idle_at == 0; k++) begin
      @(negedge clk);
      bus.start = (k == extra_at);
      if (k == 1) begin
        bus.cmd     = ~c;
        bus.payload = ~p;
      end
      if (bus.SS_n === 1'b0) begin
        if (low < 11) mosi_vec = {mosi_vec[9:0], bus.MOSI};
        else if (bus.MOSI !== 1'b0) tail++;
        low++;
      end
      if (bus.done === 1'b1) begin
        dn++;
        if (done_at == 0) done_at = k;
      end
      if (bus.rd_valid === 1'b1) begin
        rvn++;
        if (rv_at == 0) rv_at = k;
      end
      if (bus.busy === 1'b0) idle_at = k;
    end
    bus.start = 1'b0;
  endtask

  int q, pat_err;
  logic exp_low;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cmd = 2'b00;
    bus.payload = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ss_n", 32'(bus.SS_n), 1);
    chk("rst_mosi", 32'(bus.MOSI), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_rv", 32'(bus.rd_valid), 0);
    chk("rst_rd", 32'(bus.rd_data), 0);

    // read data from addr 0 (slave holds 3C)
    frame(2'b11, 8'h00, 0);
    chk("rd_low", low, 21);
    chk("rd_mosi", 32'(mosi_vec), 32'b11100000000);
    chk("rd_tail", tail, 0);
    chk("rd_done_at", done_at, 22);
    chk("rd_rv_at", rv_at, 22);
    chk("rd_rvn", rvn, 1);
    chk("rd_dn", dn, 1);
    chk("rd_data", 32'(bus.rd_data), 32'h3C);
    chk("rd_idle", idle_at, 23);

    // write address A5
    frame(2'b00, 8'hA5, 0);
    chk("wa_low", low, 11);
    chk("wa_mosi", 32'(mosi_vec), 32'b00010100101);
    chk("wa_done_at", done_at, 12);
    chk("wa_rvn", rvn, 0);
    chk("wa_hold", 32'(bus.rd_data), 32'h3C);
    chk("wa_idle", idle_at, 13);

    // write data with stray start during SHIFT
    frame(2'b01, 8'hC3, 5);
    chk("ign_dn", dn, 1);
    chk("ign_low", low, 11);
    chk("ign_mosi", 32'(mosi_vec), 32'b00111000011);
    chk("ign_busy", idle_at - done_at, GAP);
    q = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.SS_n !== 1'b1) q++;
    end
    chk("ign_quiet", q, 0);

    // start held: three back-to-back read-address frames
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd = 2'b10;
    bus.payload = 8'h77;
    pat_err = 0;
    dn = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (k == 27) bus.start = 1'b0;
      exp_low = (k <= 37) && (((k - 1) % 13) < 11);
      if (bus.SS_n !== !exp_low) pat_err++;
      if (bus.done === 1'b1) begin
        dn++;
        if (k != 12 && k != 25 && k != 38) pat_err++;
      end
    end
    chk("b2b_pattern", pat_err, 0);
    chk("b2b_dn", dn, 3);

    // RAM round trip through the slave
    frame(2'b00, 8'h10, 0);
    frame(2'b01, 8'h5A, 0);
    frame(2'b10, 8'h10, 0);
    frame(2'b11, 8'h00, 0);
    chk("ram_rvn", rvn, 1);
    chk("ram_data", 32'(bus.rd_data), 32'h5A);

    // reset during SHIFT bit 5 of a read-data frame
    @(negedge clk);
    bus.start = 1'b1;
    bus.cmd = 2'b11;
    bus.payload = 8'h00;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    chk("mid_ss_low", 32'(bus.SS_n), 0);
    chk("mid_mosi_b5", 32'(bus.MOSI), 0);
    #1 rst = 1'b1;
    #1;
    chk("mid_ss_n", 32'(bus.SS_n), 1);
    chk("mid_busy", 32'(bus.busy), 0);
    chk("mid_done", 32'(bus.done), 0);
    chk("mid_rd", 32'(bus.rd_data), 0);
    @(negedge clk);
    rst = 1'b0;
    q = 0;
    dn = 0;
    repeat (30) begin
      @(negedge clk);
      if (bus.SS_n !== 1'b1) q++;
      if (bus.done !== 1'b0 || bus.rd_valid !== 1'b0) dn++;
    end
    chk("post_quiet", q, 0);
    chk("post_nodone", dn, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
